hazard_ctrl: RTL and testbench

Parametrised successor to the decode-stage stall/bypass unit.
- Tracks destination tags of in-flight instructions internally in an E/M/W shadow pipeline; the core no longer feeds rd_e/rd_m/rd_w.
- Adds a pending-register scoreboard for a variable-latency long-op unit (mul/div), a configurable outstanding-op limit, flush handling and optional register-file write-through.
- Sits beside the decoder and drives fetch/decode stall and the per-source bypass muxes in E and M.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 51 +++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared class/select encodings and the shadow-pipeline entry type for hazard_ctrl.
package hazard_pkg;

    // Register tags are stored at this width in stage entries and zero-extended from REG_AW.
    localparam int unsigned MAX_REG_AW = 8;

    typedef enum logic [2:0] {
        CLASS_ALU    = 3'd0,
        CLASS_LOAD   = 3'd1,
        CLASS_STORE  = 3'd2,
        CLASS_JUMP   = 3'd3,
        CLASS_BRANCH = 3'd4,
        CLASS_LONG   = 3'd5
    } d_class_e;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_M2E = 2'd1,
        SEL_W2E = 2'd2,
        SEL_W2M = 2'd3
    } sel_e;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [MAX_REG_AW-1:0] rd;
        logic [2:0]            cls;
    } stage_t;

    typedef struct packed {
        logic stall;
        logic load_use;
        sel_e sel;
    } src_res_t;

    // LONG results return through long_done, never through the shadow pipeline.
    function automatic logic class_writes(input logic [2:0] cls);
        return !(cls inside {CLASS_STORE, CLASS_BRANCH, CLASS_LONG});
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-destination bits and outstanding-count tracking for the variable-latency long-op unit.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LONG_SLOTS = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     issue_i,
    input  logic [REG_AW-1:0]        issue_rd_i,
    input  logic                     done_i,
    input  logic [REG_AW-1:0]        done_rd_i,
    output logic [(2**REG_AW)-1:0]   pending_o,
    output logic                     full_o
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;
    localparam int unsigned OcW      = $clog2(LONG_SLOTS + 1);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [OcW-1:0]      oc_q, oc_d;
    logic                done_ok;

    always_comb begin
        // A completion for an unknown tag or with nothing outstanding is dropped.
        done_ok   = done_i && (oc_q != '0) && pending_q[done_rd_i];
        pending_d = pending_q;
        if (done_ok) begin
            pending_d[done_rd_i] = 1'b0;
        end
        if (issue_i && (issue_rd_i != '0)) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        oc_d = oc_q + OcW'(issue_i) - OcW'(done_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            oc_q      <= '0;
        end else begin
            pending_q <= pending_d;
            oc_q      <= oc_d;
        end
    end

    assign pending_o = pending_q;
    assign full_o    = (oc_q == OcW'(LONG_SLOTS));

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall/bypass control with an internal E/M/W tag pipeline and long-op scoreboard.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / load_use_cycles counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned LONG_SLOTS       = 2,
    parameter bit          RF_WRITE_THROUGH = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic              d_use_rs1,
    input  logic              d_use_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic [2:0]        d_class,
    input  logic              flush,
    input  logic              long_done,
    input  logic [REG_AW-1:0] long_rd,
    output logic              stall,
    output logic [1:0]        rs1_sel,
    output logic [1:0]        rs2_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       load_use_cycles
`endif
);

    localparam int unsigned NUM_REGS = 2 ** REG_AW;

    stage_t              e_q, m_q, w_q, d_entry;
    logic [NUM_REGS-1:0] pending;
    logic                long_full;
    src_res_t            rs1_res, rs2_res;
    logic                sb_stall, stall_raw, issue;

    function automatic logic [MAX_REG_AW-1:0] ext_rd(input logic [REG_AW-1:0] r);
        return MAX_REG_AW'(r);
    endfunction

    function automatic logic stage_hit(input stage_t s, input logic [REG_AW-1:0] rs);
        return s.valid && s.wr && (s.rd == ext_rd(rs));
    endfunction

    // Youngest producer wins; store data from a load in E is caught later on the W->M path.
    function automatic src_res_t check_src(input logic use_src, input logic [REG_AW-1:0] rs,
                                           input logic store_data, input stage_t e,
                                           input stage_t m, input stage_t w);
        src_res_t res;
        res = '{stall: 1'b0, load_use: 1'b0, sel: SEL_RF};
        if (use_src && (rs != '0)) begin
            if (stage_hit(e, rs)) begin
                if ((e.cls == CLASS_LOAD) && store_data) begin
                    res.sel = SEL_W2M;
                end else if (e.cls inside {CLASS_LOAD, CLASS_JUMP}) begin
                    res.stall    = 1'b1;
                    res.load_use = (e.cls == CLASS_LOAD);
                end else begin
                    res.sel = SEL_M2E;
                end
            end else if (stage_hit(m, rs)) begin
                res.sel = SEL_W2E;
            end else if (stage_hit(w, rs)) begin
                res.stall = !RF_WRITE_THROUGH;
            end
        end
        return res;
    endfunction

    always_comb begin
        rs1_res = check_src(d_use_rs1, d_rs1, 1'b0, e_q, m_q, w_q);
        rs2_res = check_src(d_use_rs2, d_rs2, d_class == CLASS_STORE, e_q, m_q, w_q);

        sb_stall = (d_use_rs1 && pending[d_rs1])
                || (d_use_rs2 && pending[d_rs2])
                || ((d_rd != '0) && pending[d_rd])
                || ((d_class == CLASS_LONG) && long_full);

        stall_raw = d_valid && (rs1_res.stall || rs2_res.stall || sb_stall);
        issue     = !reset && d_valid && !stall_raw && !flush;

        stall   = !reset && stall_raw;
        rs1_sel = (!reset && d_valid) ? rs1_res.sel : SEL_RF;
        rs2_sel = (!reset && d_valid) ? rs2_res.sel : SEL_RF;

        d_entry.valid = 1'b1;
        d_entry.wr    = (d_rd != '0) && class_writes(d_class);
        d_entry.rd    = ext_rd(d_rd);
        d_entry.cls   = d_class;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= m_q;
            m_q <= e_q;
            e_q <= issue ? d_entry : '0;
        end
    end

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .LONG_SLOTS (LONG_SLOTS)
    ) u_scoreboard (
        .clk_i      (clock),
        .rst_i      (reset),
        .issue_i    (issue && (d_class == CLASS_LONG)),
        .issue_rd_i (d_rd),
        .done_i     (long_done),
        .done_rd_i  (long_rd),
        .pending_o  (pending),
        .full_o     (long_full)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, load_use_cnt_q;
    logic        load_use_stall;

    assign load_use_stall = stall && (rs1_res.load_use || rs2_res.load_use);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            load_use_cnt_q <= '0;
        end else begin
            if (stall && !flush && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (load_use_stall && (load_use_cnt_q != '1)) begin
                load_use_cnt_q <= load_use_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles    = stall_cnt_q;
    assign load_use_cycles = load_use_cnt_q;

    logic unused_w_cls;
    assign unused_w_cls = ^w_q.cls;
`else
    logic unused_sigs;
    assign unused_sigs = ^{w_q.cls, rs1_res.load_use, rs2_res.load_use};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, multi-cycle sequences and randomized model checks.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned LONG_SLOTS = 2;
    localparam int          NREG       = 32;

    logic              clock;
    logic              reset;
    logic              d_valid;
    logic [REG_AW-1:0] d_rs1, d_rs2, d_rd, long_rd;
    logic              d_use_rs1, d_use_rs2;
    logic [2:0]        d_class;
    logic              flush, long_done;
    logic              stall0, stall1;
    logic [1:0]        rs1_sel0, rs2_sel0, rs1_sel1, rs2_sel1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       sc0, lc0, sc1, lc1;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    hazard_ctrl #(
        .REG_AW           (REG_AW),
        .LONG_SLOTS       (LONG_SLOTS),
        .RF_WRITE_THROUGH (1'b0)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_use_rs1 (d_use_rs1),
        .d_use_rs2 (d_use_rs2),
        .d_rd      (d_rd),
        .d_class   (d_class),
        .flush     (flush),
        .long_done (long_done),
        .long_rd   (long_rd),
        .stall     (stall0),
        .rs1_sel   (rs1_sel0),
        .rs2_sel   (rs2_sel0)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (sc0),
        .load_use_cycles (lc0)
`endif
    );

    hazard_ctrl #(
        .REG_AW           (REG_AW),
        .LONG_SLOTS       (LONG_SLOTS),
        .RF_WRITE_THROUGH (1'b1)
    ) dut_wt (
        .clock     (clock),
        .reset     (reset),
        .d_valid   (d_valid),
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_use_rs1 (d_use_rs1),
        .d_use_rs2 (d_use_rs2),
        .d_rd      (d_rd),
        .d_class   (d_class),
        .flush     (flush),
        .long_done (long_done),
        .long_rd   (long_rd),
        .stall     (stall1),
        .rs1_sel   (rs1_sel1),
        .rs2_sel   (rs2_sel1)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (sc1),
        .load_use_cycles (lc1)
`endif
    );

    // Reference model: index 0 mirrors dut (no write-through), index 1 mirrors dut_wt.
    typedef struct packed {
        bit valid;
        int rd;
        int cls;
    } ins_t;

    ins_t pipe [2][3];
    bit   pend [2][NREG];
    int   oc   [2];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit writes(input ins_t i);
        return i.valid && (i.rd != 0) && !(i.cls == 2 || i.cls == 4 || i.cls == 5);
    endfunction

    function automatic void model_clear(input int k);
        for (int s = 0; s < 3; s++) pipe[k][s] = '0;
        for (int r = 0; r < NREG; r++) pend[k][r] = 1'b0;
        oc[k] = 0;
    endfunction

    function automatic void model_src(input int k, input bit use_s, input int rs,
                                      input bit store_data, output bit st, output int sel);
        st  = 1'b0;
        sel = 0;
        if (!use_s || rs == 0) return;
        for (int s = 0; s < 3; s++) begin
            if (writes(pipe[k][s]) && pipe[k][s].rd == rs) begin
                if (s == 0) begin
                    if (pipe[k][s].cls == 1 && store_data) sel = 3;
                    else if (pipe[k][s].cls == 1 || pipe[k][s].cls == 3) st = 1'b1;
                    else sel = 1;
                end else if (s == 1) begin
                    sel = 2;
                end else begin
                    st = (k == 0);
                end
                return;
            end
        end
    endfunction

    function automatic void model_out(input int k, output bit st, output int s1, output int s2);
        bit st1, st2, sb;
        st = 1'b0;
        s1 = 0;
        s2 = 0;
        if (reset || !d_valid) return;
        model_src(k, d_use_rs1, int'(d_rs1), 1'b0, st1, s1);
        model_src(k, d_use_rs2, int'(d_rs2), d_class == 3'd2, st2, s2);
        sb = (d_use_rs1 && pend[k][d_rs1]) || (d_use_rs2 && pend[k][d_rs2])
          || (d_rd != 0 && pend[k][d_rd]) || (d_class == 3'd5 && oc[k] == LONG_SLOTS);
        st = st1 || st2 || sb;
    endfunction

    function automatic void model_step(input int k, input bit st);
        bit   issue;
        ins_t n;
        if (reset) begin
            model_clear(k);
            return;
        end
        issue = d_valid && !st && !flush;
        if (long_done && oc[k] > 0 && pend[k][long_rd]) begin
            pend[k][long_rd] = 1'b0;
            oc[k]--;
        end
        if (issue && d_class == 3'd5) begin
            if (d_rd != 0) pend[k][d_rd] = 1'b1;
            oc[k]++;
        end
        n.valid    = issue;
        n.rd       = issue ? int'(d_rd) : 0;
        n.cls      = issue ? int'(d_class) : 0;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = pipe[k][0];
        pipe[k][0] = n;
    endfunction

    task automatic drv(input bit rst, input bit v, input int cls, input int rd, input int rs1,
                       input bit u1, input int rs2, input bit u2, input bit fl, input bit dn,
                       input int dnrd);
        reset     = rst;
        d_valid   = v;
        d_class   = 3'(cls);
        d_rd      = REG_AW'(rd);
        d_rs1     = REG_AW'(rs1);
        d_use_rs1 = u1;
        d_rs2     = REG_AW'(rs2);
        d_use_rs2 = u2;
        flush     = fl;
        long_done = dn;
        long_rd   = REG_AW'(dnrd);
    endtask

    task automatic tick(input bit has_exp, input bit es, input int e1, input int e2,
                        input bit has_wt, input bit ws, input int w1, input int w2);
        bit mst [2];
        int m1  [2];
        int m2  [2];
        @(negedge clock);
        for (int k = 0; k < 2; k++) model_out(k, mst[k], m1[k], m2[k]);
        chk("model stall", int'(stall0), int'(mst[0]));
        chk("model rs1_sel", int'(rs1_sel0), m1[0]);
        chk("model rs2_sel", int'(rs2_sel0), m2[0]);
        chk("model_wt stall", int'(stall1), int'(mst[1]));
        chk("model_wt rs1_sel", int'(rs1_sel1), m1[1]);
        chk("model_wt rs2_sel", int'(rs2_sel1), m2[1]);
        if (has_exp) begin
            chk("vec stall", int'(stall0), int'(es));
            chk("vec rs1_sel", int'(rs1_sel0), e1);
            chk("vec rs2_sel", int'(rs2_sel0), e2);
        end
        if (has_wt) begin
            chk("vec_wt stall", int'(stall1), int'(ws));
            chk("vec_wt rs1_sel", int'(rs1_sel1), w1);
            chk("vec_wt rs2_sel", int'(rs2_sel1), w2);
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) model_step(k, mst[k]);
        #1;
    endtask

    // Single-source hand sequence step; cls < 0 means no instruction in D.
    task automatic seq(input int cls, input int rd, input int rs1, input bit u1, input bit dn,
                       input int dnrd, input bit fl, input bit es, input int e1);
        drv(1'b0, cls >= 0, (cls < 0) ? 0 : cls, rd, rs1, u1, 0, 1'b0, fl, dn, dnrd);
        tick(1'b1, es, e1, 0, 1'b1, es, e1, 0);
    endtask

    typedef struct packed {
        bit rst; bit v; int cls; int rd; int rs1; bit u1; int rs2; bit u2; bit fl; bit dn;
        int dnrd; bit st; int s1; int s2; bit wst; int w1; int w2;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    initial begin
        model_clear(0);
        model_clear(1);
        drv(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);

        //         rst v  cls rd rs1 u1 rs2 u2 fl dn dnrd st s1 s2 wst w1 w2
        vecs[0]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, 6, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        vecs[3]  = '{0, 1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 2, 1, 0, 2, 1};
        vecs[4]  = '{0, 1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 8, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[6]  = '{0, 1, 0, 8, 7, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0};
        vecs[7]  = '{0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 2, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 3, 0, 0, 3};
        vecs[9]  = '{0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 10, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[17] = '{0, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[18] = '{0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 0};
        vecs[20] = '{0, 1, 4, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[21] = '{0, 1, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        #1;
        for (int i = 0; i < NVEC; i++) begin
            drv(vecs[i].rst, vecs[i].v, vecs[i].cls, vecs[i].rd, vecs[i].rs1, vecs[i].u1,
                vecs[i].rs2, vecs[i].u2, vecs[i].fl, vecs[i].dn, vecs[i].dnrd);
            tick(1'b1, vecs[i].st, vecs[i].s1, vecs[i].s2, 1'b1, vecs[i].wst, vecs[i].w1,
                 vecs[i].w2);
        end

        // Long op RAW held until the cycle after long_done, then WAW on the same tag.
        drv(1'b1, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
        tick(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        seq(5, 9, 0, 0, 0, 0, 0, 0, 0);
        seq(0, 11, 9, 1, 0, 0, 0, 1, 0);
        seq(0, 11, 9, 1, 0, 0, 0, 1, 0);
        seq(0, 11, 9, 1, 1, 9, 0, 1, 0);
        seq(0, 11, 9, 1, 0, 0, 0, 0, 0);
        seq(5, 9, 0, 0, 0, 0, 0, 0, 0);
        seq(0, 9, 0, 0, 0, 0, 0, 1, 0);
        seq(0, 9, 0, 0, 1, 9, 0, 1, 0);
        seq(0, 9, 0, 0, 0, 0, 0, 0, 0);

        // Slot limit, then same-cycle issue and done leaving the count unchanged.
        seq(5, 12, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 13, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 14, 0, 0, 0, 0, 0, 1, 0);
        seq(5, 14, 0, 0, 1, 12, 0, 1, 0);
        seq(5, 14, 0, 0, 0, 0, 0, 0, 0);
        seq(-1, 0, 0, 0, 1, 14, 0, 0, 0);
        seq(5, 15, 0, 0, 1, 13, 0, 0, 0);
        seq(5, 16, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 17, 0, 0, 0, 0, 0, 1, 0);
        seq(0, 0, 13, 1, 0, 0, 0, 0, 0);
        seq(-1, 0, 0, 0, 1, 15, 0, 0, 0);
        seq(-1, 0, 0, 0, 1, 16, 0, 0, 0);

        // Flushed load-use stall on a LONG op must leave no pending bit or slot behind.
        seq(1, 7, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 21, 7, 1, 0, 0, 1, 1, 0);
        seq(0, 0, 21, 1, 0, 0, 0, 0, 0);
        seq(5, 22, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 23, 0, 0, 0, 0, 0, 0, 0);
        seq(5, 24, 0, 0, 0, 0, 0, 1, 0);

        // Reset mid-operation with pending/oc busy.
        drv(1'b1, 1'b1, 5, 24, 22, 1'b1, 0, 1'b0, 1'b0, 1'b1, 22);
        tick(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 0, 0);
        seq(5, 24, 0, 0, 0, 0, 0, 0, 0);
        seq(0, 0, 22, 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            d_valid   = ($urandom_range(0, 3) != 0);
            d_class   = 3'($urandom_range(0, 5));
            d_rs1     = REG_AW'($urandom_range(0, 7));
            d_rs2     = REG_AW'($urandom_range(0, 7));
            d_use_rs1 = 1'($urandom_range(0, 1));
            d_use_rs2 = 1'($urandom_range(0, 1));
            d_rd      = REG_AW'($urandom_range(0, 7));
            if (d_class == 3'd5 && d_rd == 0) d_rd = REG_AW'(1);
            flush     = ($urandom_range(0, 7) == 0);
            long_done = ($urandom_range(0, 2) == 0);
            long_rd   = REG_AW'($urandom_range(0, 7));
            tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
